aim_controller: RTL and testbench
=================================

// Module: aim_controller
// PURPOSE
//  Player-input front end for trajectory_calc. Turns raw button levels into the
//  shooter position, aim slope (rise/run) and facing direction, then issues a
//  one-cycle shoot pulse. Aim outputs are frozen until trajectory_calc returns
//  result_valid or a timeout expires. Outputs wire directly to trajectory_calc's
//  xpos, rise_in, run_in, direction_in and shoot.
// PARAMETERS
//  REPEAT_DELAY  8    cycles a move button is held before auto-repeat starts (>=1)
//  REPEAT_RATE   4    cycles between auto-repeat steps once repeating (>=1)
//  TIMEOUT       255  max cycles in WAIT before forced return to IDLE (>=1)
//  XPOS_INIT     0    reset value of xpos (0..31)
//  RISE_INIT     1    reset value of rise_out (0..31)
//  RUN_INIT      1    reset value of run_out (1..31)
// PORTS
//  clk            in   1  clock; all logic on the rising edge
//  rst            in   1  synchronous, active-high reset
//  btn_left       in   1  level; move shooter left, set direction_out=0
//  btn_right      in   1  level; move shooter right, set direction_out=1
//  btn_up         in   1  level; rise +1
//  btn_down       in   1  level; rise -1
//  btn_run        in   1  level; run +1, cyclic over 1..31
//  btn_fire       in   1  level; request a shot (rising edge only)
//  result_valid   in   1  from trajectory_calc; shot has been resolved
//  xpos           out  5  shooter x position
//  rise_out       out  5  aim rise
//  run_out        out  5  aim run, never 0
//  direction_out  out  1  1=right, 0=left
//  shoot          out  1  one-cycle fire pulse
//  busy           out  1  high in FIRE and WAIT
//  timeout        out  1  one-cycle pulse when WAIT expires without result_valid
// BEHAVIOUR
//  Reset (sync): state=IDLE. xpos=XPOS_INIT, rise_out=RISE_INIT, run_out=RUN_INIT,
//   direction_out=1, shoot=0, busy=0, timeout=0. Edge/repeat registers cleared;
//   buttons held through reset count as a new press on the first cycle after it.
//  Button step logic (all buttons except fire), one hold counter per button:
//   - A step fires on the cycle after a rising edge (prev=0, now=1).
//   - While the button stays held, a further step fires REPEAT_DELAY cycles
//     after the first step, then every REPEAT_RATE cycles after that.
//   - Release clears that button's counter.
//   - btn_fire: rising edge only, no repeat.
//  Arithmetic (all registered, 1-cycle latency from step to output):
//   - xpos: saturating 0..31.
//   - rise_out: saturating 0..31.
//   - run_out: 31+1 wraps to 1; value 0 is unreachable.
//   - Left step sets direction_out=0 even when xpos is already 0; right step
//     sets it to 1 even when xpos is 31.
//  Conflicts in the same cycle:
//   - left and right both stepping: no xpos change, direction unchanged.
//   - up and down both stepping: no rise change.
//   - Fire edge together with any step: the step is discarded and the shot
//     uses the current register values.
//  FSM:
//   - IDLE: aim updates allowed; busy=0. Fire edge -> FIRE.
//     result_valid is ignored in IDLE.
//   - FIRE (1 cycle): shoot=1, busy=1. Aim registers frozen. -> WAIT.
//     The wait counter clears here.
//   - WAIT: busy=1, aim frozen. All buttons are ignored, including fire, but
//     edge history keeps tracking so no stale edge is replayed.
//     result_valid=1 -> IDLE. Otherwise, when the counter reaches TIMEOUT:
//     timeout=1 for one cycle -> IDLE.
//     If result_valid and the timeout occur in the same cycle, result_valid
//     wins and timeout stays 0.
//   - Earliest re-fire: a fire edge in the first IDLE cycle is accepted.
//  Aim outputs stay constant from the FIRE cycle until the return to IDLE.
//   trajectory_calc may sample them on any of those cycles.
//  rst asserted in FIRE or WAIT: next cycle is IDLE with reset values.
//   No shoot or timeout pulse is emitted.
// TESTING
//  1. rst, then btn_right held 20 cycles (DELAY=8, RATE=4) -> xpos steps at
//     cycles 1, 9, 13, 17: final xpos=4, direction_out=1.
//  2. xpos=0, btn_left pulse -> xpos stays 0, direction_out=0.
//     rise_out=31 with btn_up pulse -> stays 31.
//     run_out=31 with btn_run pulse -> run_out=1.
//  3. btn_fire edge together with btn_up edge, rise_out=5 -> shoot high exactly
//     1 cycle, rise_out stays 5, busy=1.
//     Buttons pressed during WAIT cause no change.
//  4. Shot in WAIT, result_valid pulsed 10 cycles later -> busy drops the next
//     cycle, timeout stays 0.
//     A fire edge in that first IDLE cycle produces a new shoot pulse.
//  5. TIMEOUT=16 with no result_valid -> timeout pulses once, 16 cycles after
//     FIRE, then IDLE. Also: result_valid on the timeout cycle -> timeout=0.
//  6. rst asserted mid-WAIT with xpos=12 -> next cycle: IDLE, busy=0, shoot=0,
//     xpos=XPOS_INIT.

Source files
------------

// File: rtl/aim_controller.sv
// Player-input front end for trajectory_calc: debounced-style step/auto-repeat
// buttons drive shooter position and aim slope, and a fire FSM issues shots.
module aim_controller #(
    parameter int unsigned REPEAT_DELAY = 8,
    parameter int unsigned REPEAT_RATE  = 4,
    parameter int unsigned TIMEOUT      = 255,
    parameter int unsigned XPOS_INIT    = 0,
    parameter int unsigned RISE_INIT    = 1,
    parameter int unsigned RUN_INIT     = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_run,
    input  logic       btn_fire,
    input  logic       result_valid,
    output logic [4:0] xpos,
    output logic [4:0] rise_out,
    output logic [4:0] run_out,
    output logic       direction_out,
    output logic       shoot,
    output logic       busy,
    output logic       timeout
);

    localparam int unsigned MAX_HOLD = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned CW       = $clog2(MAX_HOLD + 1);
    localparam int unsigned WW       = $clog2(TIMEOUT + 1);

    localparam int unsigned B_LEFT  = 0;
    localparam int unsigned B_RIGHT = 1;
    localparam int unsigned B_UP    = 2;
    localparam int unsigned B_DOWN  = 3;
    localparam int unsigned B_RUN   = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FIRE,
        S_WAIT
    } state_t;

    state_t          state_q, state_d;
    logic [4:0]      xpos_q, xpos_d;
    logic [4:0]      rise_q, rise_d;
    logic [4:0]      run_q, run_d;
    logic            dir_q, dir_d;
    logic [WW-1:0]   wcnt_q, wcnt_d;
    logic [4:0]      prev_q;
    logic            fire_prev_q;
    logic [CW-1:0]   hold_q [5];
    logic [CW-1:0]   hold_d [5];
    logic [4:0]      rep_q, rep_d;
    logic [4:0]      btn_now;
    logic [4:0]      step;
    logic            fire_edge;

    assign btn_now   = {btn_run, btn_down, btn_up, btn_right, btn_left};
    assign fire_edge = btn_fire & ~fire_prev_q;

    // Per-button hold counter: counts cycles since the last step; rep_q selects
    // whether the next repeat is due after REPEAT_DELAY or REPEAT_RATE cycles.
    always_comb begin
        hold_d = hold_q;
        rep_d  = rep_q;
        step   = '0;
        for (int unsigned i = 0; i < 5; i++) begin
            if (!btn_now[i]) begin
                hold_d[i] = '0;
                rep_d[i]  = 1'b0;
            end else if (!prev_q[i]) begin
                step[i]   = 1'b1;
                hold_d[i] = CW'(1);
                rep_d[i]  = 1'b0;
            end else if (hold_q[i] == (rep_q[i] ? CW'(REPEAT_RATE) : CW'(REPEAT_DELAY))) begin
                step[i]   = 1'b1;
                hold_d[i] = CW'(1);
                rep_d[i]  = 1'b1;
            end else begin
                hold_d[i] = hold_q[i] + CW'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        xpos_d  = xpos_q;
        rise_d  = rise_q;
        run_d   = run_q;
        dir_d   = dir_q;
        wcnt_d  = wcnt_q;
        shoot   = 1'b0;
        busy    = 1'b0;
        timeout = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (fire_edge) begin
                    state_d = S_FIRE;
                end else begin
                    if (step[B_LEFT] && !step[B_RIGHT]) begin
                        dir_d = 1'b0;
                        if (xpos_q != 5'd0) xpos_d = xpos_q - 5'd1;
                    end else if (step[B_RIGHT] && !step[B_LEFT]) begin
                        dir_d = 1'b1;
                        if (xpos_q != 5'd31) xpos_d = xpos_q + 5'd1;
                    end
                    if (step[B_UP] && !step[B_DOWN]) begin
                        if (rise_q != 5'd31) rise_d = rise_q + 5'd1;
                    end else if (step[B_DOWN] && !step[B_UP]) begin
                        if (rise_q != 5'd0) rise_d = rise_q - 5'd1;
                    end
                    if (step[B_RUN]) run_d = (run_q == 5'd31) ? 5'd1 : run_q + 5'd1;
                end
            end
            S_FIRE: begin
                shoot   = 1'b1;
                busy    = 1'b1;
                wcnt_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                busy = 1'b1;
                if (result_valid) begin
                    state_d = S_IDLE;
                end else if (wcnt_q == WW'(TIMEOUT - 1)) begin
                    timeout = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    wcnt_d = wcnt_q + WW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
        // A reset landing in FIRE/WAIT must not leak a pulse on that cycle.
        if (rst) begin
            shoot   = 1'b0;
            timeout = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            xpos_q      <= 5'(XPOS_INIT);
            rise_q      <= 5'(RISE_INIT);
            run_q       <= 5'(RUN_INIT);
            dir_q       <= 1'b1;
            wcnt_q      <= '0;
            prev_q      <= '0;
            fire_prev_q <= 1'b0;
            hold_q      <= '{default: '0};
            rep_q       <= '0;
        end else begin
            state_q     <= state_d;
            xpos_q      <= xpos_d;
            rise_q      <= rise_d;
            run_q       <= run_d;
            dir_q       <= dir_d;
            wcnt_q      <= wcnt_d;
            prev_q      <= btn_now;
            fire_prev_q <= btn_fire;
            hold_q      <= hold_d;
            rep_q       <= rep_d;
        end
    end

    assign xpos          = xpos_q;
    assign rise_out      = rise_q;
    assign run_out       = run_q;
    assign direction_out = dir_q;

endmodule

// File: tb/tb_aim_controller.sv
// Directed bench for aim_controller with hand-computed expectations
// (REPEAT_DELAY=8, REPEAT_RATE=4, TIMEOUT=16).
module tb_aim_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_left = 1'b0, btn_right = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
    logic       btn_run = 1'b0, btn_fire = 1'b0, result_valid = 1'b0;
    logic [4:0] xpos, rise_out, run_out;
    logic       direction_out, shoot, busy, timeout;

    int n_cmp = 0;
    int n_err = 0;

    aim_controller #(
        .REPEAT_DELAY(8),
        .REPEAT_RATE (4),
        .TIMEOUT     (16),
        .XPOS_INIT   (0),
        .RISE_INIT   (1),
        .RUN_INIT    (1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_left     (btn_left),
        .btn_right    (btn_right),
        .btn_up       (btn_up),
        .btn_down     (btn_down),
        .btn_run      (btn_run),
        .btn_fire     (btn_fire),
        .result_valid (result_valid),
        .xpos         (xpos),
        .rise_out     (rise_out),
        .run_out      (run_out),
        .direction_out(direction_out),
        .shoot        (shoot),
        .busy         (busy),
        .timeout      (timeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        // 1: reset values and auto-repeat timing
        do_reset();
        chk("rst_xpos", 32'(xpos), 0);
        chk("rst_rise", 32'(rise_out), 1);
        chk("rst_run", 32'(run_out), 1);
        chk("rst_dir", 32'(direction_out), 1);
        chk("rst_shoot", 32'(shoot), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_timeout", 32'(timeout), 0);
        btn_right = 1'b1;
        repeat (8) tick();
        chk("rep_x_at8", 32'(xpos), 1);
        tick();
        chk("rep_x_at9", 32'(xpos), 2);
        repeat (11) tick();
        chk("rep_x_at20", 32'(xpos), 4);
        chk("rep_dir", 32'(direction_out), 1);
        btn_right = 1'b0;
        tick();

        // 2: saturation, wrap, conflicts
        do_reset();
        btn_left = 1'b1;
        tick();
        chk("left_sat_x", 32'(xpos), 0);
        chk("left_sat_dir", 32'(direction_out), 0);
        btn_left = 1'b0;
        tick();
        btn_right = 1'b1;
        tick();
        chk("right_x", 32'(xpos), 1);
        chk("right_dir", 32'(direction_out), 1);
        btn_right = 1'b0;
        tick();
        btn_left = 1'b1;
        btn_right = 1'b1;
        tick();
        chk("lr_conflict_x", 32'(xpos), 1);
        chk("lr_conflict_dir", 32'(direction_out), 1);
        btn_left = 1'b0;
        btn_right = 1'b0;
        tick();
        btn_up = 1'b1;
        repeat (200) tick();
        chk("up_hold_sat", 32'(rise_out), 31);
        btn_up = 1'b0;
        tick();
        btn_up = 1'b1;
        tick();
        chk("up_pulse_sat", 32'(rise_out), 31);
        btn_up = 1'b0;
        tick();
        btn_run = 1'b1;
        repeat (120) tick();
        chk("run_at120", 32'(run_out), 30);
        tick();
        chk("run_at121", 32'(run_out), 31);
        btn_run = 1'b0;
        tick();
        btn_run = 1'b1;
        tick();
        chk("run_wrap", 32'(run_out), 1);
        btn_run = 1'b0;
        tick();

        // 3: fire with simultaneous step, buttons ignored in WAIT, then timeout
        do_reset();
        for (int i = 0; i < 4; i++) begin
            btn_up = 1'b1;
            tick();
            btn_up = 1'b0;
            tick();
        end
        chk("rise_5", 32'(rise_out), 5);
        btn_fire = 1'b1;
        btn_up = 1'b1;
        tick();
        chk("fire_shoot", 32'(shoot), 1);
        chk("fire_busy", 32'(busy), 1);
        chk("fire_rise", 32'(rise_out), 5);
        tick();
        chk("wait_shoot", 32'(shoot), 0);
        chk("wait_busy", 32'(busy), 1);
        chk("wait_rise", 32'(rise_out), 5);
        btn_fire = 1'b0;
        btn_up = 1'b0;
        btn_left = 1'b1;
        btn_down = 1'b1;
        tick();
        btn_left = 1'b0;
        btn_down = 1'b0;
        btn_fire = 1'b1;
        tick();
        chk("wait_dir_frozen", 32'(direction_out), 1);
        chk("wait_rise_frozen", 32'(rise_out), 5);
        chk("wait_fire_ignored", 32'(shoot), 0);
        chk("wait_busy2", 32'(busy), 1);
        btn_fire = 1'b0;
        repeat (12) tick();
        chk("to_before", 32'(timeout), 0);
        chk("to_before_busy", 32'(busy), 1);
        tick();
        chk("to_pulse", 32'(timeout), 1);
        tick();
        chk("to_after", 32'(timeout), 0);
        chk("to_idle_busy", 32'(busy), 0);
        chk("to_idle_shoot", 32'(shoot), 0);

        // 4: result_valid return and immediate re-fire
        btn_fire = 1'b1;
        tick();
        chk("shot2_shoot", 32'(shoot), 1);
        btn_fire = 1'b0;
        repeat (10) tick();
        chk("rv_busy_before", 32'(busy), 1);
        result_valid = 1'b1;
        #1;
        chk("rv_no_timeout", 32'(timeout), 0);
        tick();
        result_valid = 1'b0;
        chk("rv_busy_after", 32'(busy), 0);
        chk("rv_timeout_after", 32'(timeout), 0);
        btn_fire = 1'b1;
        tick();
        chk("refire_shoot", 32'(shoot), 1);
        chk("refire_busy", 32'(busy), 1);
        btn_fire = 1'b0;

        // 5: result_valid on the timeout cycle wins
        repeat (16) tick();
        chk("to2_pulse", 32'(timeout), 1);
        result_valid = 1'b1;
        #1;
        chk("to2_rv_wins", 32'(timeout), 0);
        tick();
        result_valid = 1'b0;
        chk("to2_idle_busy", 32'(busy), 0);
        chk("to2_idle_timeout", 32'(timeout), 0);

        // 6: reset in the middle of WAIT
        do_reset();
        btn_right = 1'b1;
        repeat (49) tick();
        btn_right = 1'b0;
        chk("x_12", 32'(xpos), 12);
        tick();
        btn_fire = 1'b1;
        tick();
        btn_fire = 1'b0;
        repeat (5) tick();
        chk("mid_wait_busy", 32'(busy), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstw_busy", 32'(busy), 0);
        chk("rstw_shoot", 32'(shoot), 0);
        chk("rstw_timeout", 32'(timeout), 0);
        chk("rstw_xpos", 32'(xpos), 0);
        chk("rstw_rise", 32'(rise_out), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
